// File: rtl/heartbeat_monitor.sv
// Heartbeat monitor: measures the edge-to-edge spacing of a remote LED toggle,
// locks after a run of in-window half-periods and latches a sticky fault on loss.
module heartbeat_monitor #(
    parameter int unsigned CLOCK_VALUE = 300000000,
    parameter int unsigned TOL_SHIFT   = 3,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic        ACLOCK,
    input  logic        RESETN,
    input  logic        ENABLE,
    input  logic        HB_IN,
    output logic        EDGE_PULSE,
    output logic [31:0] HALF_PERIOD,
    output logic        ALIVE,
    output logic        FAULT
);

    localparam logic [32:0] NOM_HALF  = 33'(CLOCK_VALUE >> 1) + 33'd1;
    localparam logic [32:0] TOL_HALF  = NOM_HALF >> TOL_SHIFT;
    localparam logic [32:0] WIN_LO    = NOM_HALF - TOL_HALF;
    localparam logic [32:0] WIN_HI    = NOM_HALF + TOL_HALF;
    localparam logic [3:0]  LOCK_GOAL = 4'(LOCK_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [2:0]  sync_r;
    logic        edge_s;
    logic [31:0] cnt_r;
    logic [31:0] cnt_next_s;
    logic [32:0] cnt_p1_s;
    logic [31:0] meas_s;
    logic        good_meas_s;
    logic        timeout_s;
    logic        hp_load_s;
    logic [3:0]  good_r;
    logic [3:0]  good_next_s;
    logic        alive_next_s;
    logic        fault_next_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    function automatic logic [31:0] sat33to32(input logic [32:0] v);
        if (v[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return v[31:0];
        end
    endfunction

    // Two-flop synchronizer plus a delay flop for edge detection of HB_IN.
    always_ff @(posedge ACLOCK or negedge RESETN) begin
        if (!RESETN) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], HB_IN};
        end
    end

    assign edge_s      = sync_r[1] ^ sync_r[2];
    assign cnt_p1_s    = {1'b0, cnt_r} + 33'd1;
    assign meas_s      = sat33to32(cnt_p1_s);
    assign good_meas_s = (cnt_p1_s >= WIN_LO) && (cnt_p1_s <= WIN_HI);
    assign timeout_s   = !edge_s && (cnt_p1_s > WIN_HI);

    // Next-state and good-run bookkeeping; a low ENABLE overrides every event.
    always_comb begin
        state_next_s = state_r;
        good_next_s  = good_r;
        if (!ENABLE) begin
            state_next_s = ST_IDLE;
            good_next_s  = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_ACQUIRE;
                    good_next_s  = 4'd0;
                end
                ST_ACQUIRE: begin
                    good_next_s = 4'd0;
                    if (edge_s) begin
                        state_next_s = ST_MEASURE;
                    end else begin
                        state_next_s = ST_ACQUIRE;
                    end
                end
                ST_MEASURE: begin
                    if (edge_s) begin
                        if (good_meas_s) begin
                            good_next_s = good_r + 4'd1;
                            if ((good_r + 4'd1) == LOCK_GOAL) begin
                                state_next_s = ST_LOCKED;
                            end else begin
                                state_next_s = ST_MEASURE;
                            end
                        end else begin
                            good_next_s  = 4'd0;
                            state_next_s = ST_MEASURE;
                        end
                    end else if (timeout_s) begin
                        good_next_s  = 4'd0;
                        state_next_s = ST_ACQUIRE;
                    end else begin
                        state_next_s = ST_MEASURE;
                    end
                end
                ST_LOCKED: begin
                    if ((edge_s && !good_meas_s) || timeout_s) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        state_next_s = ST_LOCKED;
                    end
                end
                ST_FAULT: begin
                    state_next_s = ST_FAULT;
                end
                default: begin
                    state_next_s = ST_IDLE;
                    good_next_s  = 4'd0;
                end
            endcase
        end
    end

    // Counter and measurement-load decisions derived from the current state.
    always_comb begin
        cnt_next_s = cnt_r;
        hp_load_s  = 1'b0;
        if (!ENABLE || (state_r == ST_IDLE)) begin
            cnt_next_s = 32'd0;
        end else if (edge_s) begin
            cnt_next_s = 32'd0;
        end else begin
            cnt_next_s = sat_inc(cnt_r);
        end
        // The acquiring edge only starts the count; it is not a measurement.
        if (ENABLE && edge_s &&
            ((state_r == ST_MEASURE) || (state_r == ST_LOCKED) || (state_r == ST_FAULT))) begin
            hp_load_s = 1'b1;
        end else begin
            hp_load_s = 1'b0;
        end
    end

    // Output decode of the upcoming state so ALIVE/FAULT are registered.
    always_comb begin
        alive_next_s = 1'b0;
        fault_next_s = 1'b0;
        case (state_next_s)
            ST_LOCKED: begin
                alive_next_s = 1'b1;
                fault_next_s = 1'b0;
            end
            ST_FAULT: begin
                alive_next_s = 1'b0;
                fault_next_s = 1'b1;
            end
            default: begin
                alive_next_s = 1'b0;
                fault_next_s = 1'b0;
            end
        endcase
    end

    // State register and all monitor datapath registers.
    always_ff @(posedge ACLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 32'd0;
            good_r      <= 4'd0;
            HALF_PERIOD <= 32'd0;
            EDGE_PULSE  <= 1'b0;
            ALIVE       <= 1'b0;
            FAULT       <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            good_r     <= good_next_s;
            EDGE_PULSE <= edge_s;
            ALIVE      <= alive_next_s;
            FAULT      <= fault_next_s;
            if (hp_load_s) begin
                HALF_PERIOD <= meas_s;
            end else begin
                HALF_PERIOD <= HALF_PERIOD;
            end
        end
    end

endmodule

// File: doc/heartbeat_monitor.md
HEARTBEAT_MONITOR -- requirements
Module: heartbeat_monitor

Interface
REQ-001 SHALL have parameter CLOCK_VALUE, default 300000000, meaning ACLOCK frequency in Hz; nominal heartbeat half-period N = (CLOCK_VALUE>>1)+1 cycles.
REQ-002 SHALL have parameter TOL_SHIFT, default 3, meaning tolerance T = N>>TOL_SHIFT; the acceptance window is [N-T, N+T] cycles inclusive.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive in-window half-periods required to lock (range 1..15).
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port ACLOCK, input, 1 bit: the single clock.
REQ-006 SHALL have port RESETN, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port ENABLE, input, 1 bit: synchronous monitor enable; low forces the IDLE state.
REQ-008 SHALL have port HB_IN, input, 1 bit: asynchronous heartbeat/LED toggle from the remote camera controller.
REQ-009 SHALL have port EDGE_PULSE, output, 1 bit: one-cycle pulse on each detected HB_IN edge, either polarity.
REQ-010 SHALL have port HALF_PERIOD, output, 32 bits: last measured edge-to-edge spacing in cycles.
REQ-011 SHALL have port ALIVE, output, 1 bit: high only in the LOCKED state.
REQ-012 SHALL have port FAULT, output, 1 bit: high only in the FAULT state.

Function
REQ-013 SHALL pass HB_IN through a 2-flop synchronizer followed by a third flop; an edge is defined as the XOR of flop 2 and flop 3.
- EDGE_PULSE asserts 3 cycles after the HB_IN transition is sampled.
REQ-014 SHALL maintain a 32-bit cycle counter CNT with these rules:
- cleared to 0 in an edge cycle;
- incremented otherwise;
- saturating at 0xFFFFFFFF.
REQ-015 SHALL, in an edge cycle while not IDLE, load HALF_PERIOD with CNT+1, computed in 33 bits and saturated to 32 bits; edges D cycles apart yield D.
REQ-016 SHALL treat a measurement as good iff N-T <= CNT+1 <= N+T.
REQ-017 SHALL declare a timeout when CNT+1 exceeds N+T with no edge in that cycle.
REQ-018 SHALL implement the states IDLE, ACQUIRE, MEASURE, LOCKED and FAULT, with a 4-bit good-run counter GOOD.
REQ-019 In IDLE:
- CNT=0 and GOOD=0;
- the edge detector continues running;
- ENABLE=1 moves to ACQUIRE on the next cycle.
REQ-020 In ACQUIRE, the first edge clears CNT and moves to MEASURE with GOOD=0; no HALF_PERIOD update occurs from this edge.
REQ-021 In MEASURE:
- a good edge increments GOOD;
- when GOOD reaches LOCK_COUNT, move to LOCKED;
- a bad edge sets GOOD=0 and stays in MEASURE;
- a timeout moves to ACQUIRE with GOOD=0.
REQ-022 In LOCKED:
- a good edge stays in LOCKED;
- a bad edge or a timeout moves to FAULT.
REQ-023 FAULT SHALL be sticky; only ENABLE=0 or reset leaves it, going to IDLE.
REQ-024 ENABLE=0 in any state SHALL move to IDLE on the next cycle, with priority over edge and timeout events.
REQ-025 If an edge and the timeout threshold coincide in the same cycle, the edge SHALL win and be evaluated as a measurement.
REQ-026 ALIVE and FAULT SHALL be registered state decodes, valid in the cycle after the deciding edge or timeout.

Reset
REQ-027 SHALL, while RESETN=0, asynchronously clear the following: all synchronizer flops, CNT, GOOD, HALF_PERIOD, EDGE_PULSE, ALIVE and FAULT; state = IDLE.
REQ-028 SHALL leave IDLE no earlier than the first ACLOCK edge after RESETN deasserts; a reset mid-operation discards lock and fault history.

Verification (CLOCK_VALUE=30 -> N=16, T=2, window [14,18], LOCK_COUNT=4)
REQ-029 SHALL cover this scenario: ENABLE=1, HB_IN toggles every 16 cycles -> HALF_PERIOD=16 and ALIVE=1 after the 5th edge (1 acquire + 4 good); FAULT=0.
REQ-030 SHALL cover this scenario: lock at 16, then one half-period of 19 -> FAULT=1 and ALIVE=0 the cycle after that edge; FAULT persists until ENABLE=0, then IDLE, then relock.
REQ-031 SHALL cover this scenario: lock at 16, then HB_IN held static -> FAULT=1 when CNT+1 reaches 19 (19 cycles after the last edge).
REQ-032 SHALL cover this scenario: spacings 14,18,14,18 -> lock (inclusive bounds); the sequence 16,16,13,16,16,16,16 -> GOOD resets at 13, lock only after the 4th subsequent 16.
REQ-033 SHALL cover this scenario: RESETN pulsed low mid-LOCKED, asynchronous to ACLOCK -> all outputs 0 immediately; relock requires 5 fresh edges.
REQ-034 SHALL cover this scenario: ENABLE dropped in the same cycle as an edge in MEASURE -> IDLE next cycle with GOOD=0, and HALF_PERIOD keeps its previous value.
